adc_pd_seq: RTL and testbench

- Parametrised power-down/power-up sequencer for the AD7822/AD7825 PD pin (Pin9).
- Holds the ADC powered down for a minimum time, then powers it up and raises ADC_ready after a programmable on-chip-reference settle time (≥25 µs).
- Unlike the fixed one-shot sequencer, it supports repeated power-down on request, abort during wake, and optional auto-sleep after an idle timeout with wake-on-activity.
- Sits between system control and the CONVST generator; conversions are started only while ADC_ready=1.

---
 rtl/adc_pd_seq.sv | 122 ++++++++++++
 tb/tb_adc_pd_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/adc_pd_seq.sv
// Power-down / power-up sequencer for the AD7822/AD7825 PD pin.
// Holds the ADC in power-down for at least OFF_MIN edges, then raises PD and
// waits WAKE_CYCLES edges for the on-chip reference to settle before raising
// ADC_ready. Supports forced power-down, abort during wake, and optional
// auto-sleep after IDLE_TIMEOUT idle READY edges with wake-on-activity.
module adc_pd_seq #(
    parameter int OFF_MIN      = 1,
    parameter int WAKE_CYCLES  = 6,
    parameter int IDLE_TIMEOUT = 0,
    parameter int CNT_W        = 8
) (
    input  logic       clk_200kHz,
    input  logic       reset,
    input  logic       pd_req,
    input  logic       activity,
    output logic       PD,
    output logic       ADC_ready,
    output logic       sleeping,
    output logic [1:0] pwr_state
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    // Counter thresholds pre-sized to the counter so all compares are width-matched.
    // IDLE_LAST wraps to all-ones when auto-sleep is disabled; it is never used then.
    localparam logic [CNT_W-1:0] OFF_MIN_C = CNT_W'(OFF_MIN);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic             IDLE_EN   = (IDLE_TIMEOUT > 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pd_q, pd_d;
    logic             rdy_q, rdy_d;
    logic             sleep_q, sleep_d;

    // State, counter and all outputs registered; reset aborts on the edge it is seen.
    always_ff @(posedge clk_200kHz) begin
        if (!reset) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            pd_q    <= 1'b0;
            rdy_q   <= 1'b0;
            sleep_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pd_q    <= pd_d;
            rdy_q   <= rdy_d;
            sleep_q <= sleep_d;
        end
    end

    // Next-state logic; priority is pd_req > idle timeout > activity.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pd_d    = pd_q;
        rdy_d   = rdy_q;
        sleep_d = sleep_q;
        case (state_q)
            ST_OFF: begin
                if (cnt_q < OFF_MIN_C) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!pd_req && (!sleep_q || activity)) begin
                    state_d = ST_WAKE;
                    pd_d    = 1'b1;
                    cnt_d   = '0;
                    sleep_d = 1'b0;
                end
            end
            ST_WAKE: begin
                if (pd_req) begin
                    state_d = ST_OFF;
                    pd_d    = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == WAKE_LAST) begin
                    state_d = ST_READY;
                    rdy_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (pd_req) begin
                    state_d = ST_OFF;
                    pd_d    = 1'b0;
                    rdy_d   = 1'b0;
                    cnt_d   = '0;
                end else if (IDLE_EN && !activity && (cnt_q == IDLE_LAST)) begin
                    state_d = ST_OFF;
                    pd_d    = 1'b0;
                    rdy_d   = 1'b0;
                    sleep_d = 1'b1;
                    cnt_d   = '0;
                end else if (activity) begin
                    cnt_d = '0;
                end else if (IDLE_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_OFF;
                pd_d    = 1'b0;
                rdy_d   = 1'b0;
                sleep_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign PD        = pd_q;
    assign ADC_ready = rdy_q;
    assign sleeping  = sleep_q;
    assign pwr_state = state_q;

endmodule

// File: tb/tb_adc_pd_seq.sv
// Scoreboard bench for adc_pd_seq: three instances (defaults, auto-sleep,
// long OFF / short WAKE) share stimulus; each queued expectation names the
// instance whose registered outputs it describes after the next rising edge.
`timescale 1ns/1ps
module tb_adc_pd_seq;

    localparam logic [1:0] S_OFF = 2'd0, S_WAKE = 2'd1, S_READY = 2'd2;

    logic       clk;
    logic       reset, pd_req, activity;
    logic [2:0] pd_o, rdy_o, slp_o;
    logic [5:0] st_o;

    typedef struct {
        int         d;
        logic       pd;
        logic       rdy;
        logic       slp;
        logic [1:0] st;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #2500 clk = ~clk;

    adc_pd_seq u_def (
        .clk_200kHz(clk), .reset(reset), .pd_req(pd_req), .activity(activity),
        .PD(pd_o[0]), .ADC_ready(rdy_o[0]), .sleeping(slp_o[0]), .pwr_state(st_o[1:0])
    );

    adc_pd_seq #(.IDLE_TIMEOUT(10)) u_idle (
        .clk_200kHz(clk), .reset(reset), .pd_req(pd_req), .activity(activity),
        .PD(pd_o[1]), .ADC_ready(rdy_o[1]), .sleeping(slp_o[1]), .pwr_state(st_o[3:2])
    );

    adc_pd_seq #(.OFF_MIN(3), .WAKE_CYCLES(1)) u_short (
        .clk_200kHz(clk), .reset(reset), .pd_req(pd_req), .activity(activity),
        .PD(pd_o[2]), .ADC_ready(rdy_o[2]), .sleeping(slp_o[2]), .pwr_state(st_o[5:4])
    );

    function automatic bit cnt_fits(input int w, input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (64'(1) << w) > 64'(m);
    endfunction

    // Counter width must hold the largest count of every configuration used here.
    initial begin
        if (!(cnt_fits(8, 1, 6, 0) && cnt_fits(8, 1, 6, 10) && cnt_fits(8, 3, 1, 0))) begin
            $display("FAIL cnt_w: CNT_W=8 too narrow for configured counts");
            $fatal(1, "counter width");
        end
    end

    // Monitor: after each rising edge, compare the oldest pending expectation.
    initial begin
        exp_t       e;
        logic [1:0] st;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e  = q.pop_front();
                st = st_o[2*e.d +: 2];
                checks++;
                if (pd_o[e.d] !== e.pd || rdy_o[e.d] !== e.rdy ||
                    slp_o[e.d] !== e.slp || st !== e.st) begin
                    failures++;
                    $display("FAIL %s dut%0d: got pd=%b rdy=%b slp=%b st=%0d, want pd=%b rdy=%b slp=%b st=%0d",
                             e.nm, e.d, pd_o[e.d], rdy_o[e.d], slp_o[e.d], st,
                             e.pd, e.rdy, e.slp, e.st);
                end
            end
        end
    end

    task automatic step(input int d, input logic rn, input logic pr, input logic act,
                        input logic epd, input logic erdy, input logic eslp,
                        input logic [1:0] est, input string nm);
        exp_t e;
        @(negedge clk);
        reset    = rn;
        pd_req   = pr;
        activity = act;
        e = '{d, epd, erdy, eslp, est, nm};
        q.push_back(e);
    endtask

    task automatic run(input int n, input int d, input logic rn, input logic pr, input logic act,
                       input logic epd, input logic erdy, input logic eslp,
                       input logic [1:0] est, input string nm);
        for (int i = 0; i < n; i++) step(d, rn, pr, act, epd, erdy, eslp, est, nm);
    endtask

    initial begin
        reset = 1'b0; pd_req = 1'b0; activity = 1'b0;

        // Default power-up: PD at edge 2, ADC_ready at edge 8
        run(3, 0, 0, 0, 0, 0, 0, 0, S_OFF,   "t1_reset");
        run(1, 0, 1, 0, 0, 0, 0, 0, S_OFF,   "t1_off_min");
        run(1, 0, 1, 0, 0, 1, 0, 0, S_WAKE,  "t1_pd_rise");
        run(5, 0, 1, 0, 0, 1, 0, 0, S_WAKE,  "t1_wake");
        run(1, 0, 1, 0, 0, 1, 1, 0, S_READY, "t1_ready_rise");
        run(5, 0, 1, 0, 0, 1, 1, 0, S_READY, "t1_ready_hold");

        // One-edge pd_req pulse in READY
        run(1, 0, 1, 1, 0, 0, 0, 0, S_OFF,   "t2_pd_drop");
        run(1, 0, 1, 0, 0, 0, 0, 0, S_OFF,   "t2_off");
        run(1, 0, 1, 0, 0, 1, 0, 0, S_WAKE,  "t2_pd_rerise");
        run(5, 0, 1, 0, 0, 1, 0, 0, S_WAKE,  "t2_wake");
        run(1, 0, 1, 0, 0, 1, 1, 0, S_READY, "t2_ready");

        // Abort on the 3rd WAKE edge, then pd_req held long
        run(1, 0, 1, 1, 0, 0, 0, 0, S_OFF,   "t3_pd_drop");
        run(1, 0, 1, 0, 0, 0, 0, 0, S_OFF,   "t3_off");
        run(2, 0, 1, 0, 0, 1, 0, 0, S_WAKE,  "t3_wake_pre");
        run(1, 0, 1, 1, 0, 0, 0, 0, S_OFF,   "t3_abort");
        run(1, 0, 1, 0, 0, 0, 0, 0, S_OFF,   "t3_off_again");
        run(1, 0, 1, 0, 0, 1, 0, 0, S_WAKE,  "t3_pd_rerise");
        run(5, 0, 1, 0, 0, 1, 0, 0, S_WAKE,  "t3_no_early_ready");
        run(1, 0, 1, 0, 0, 1, 1, 0, S_READY, "t3_ready");
        run(10, 0, 1, 1, 0, 0, 0, 0, S_OFF,  "t3_pd_hold");
        run(1, 0, 1, 0, 0, 1, 0, 0, S_WAKE,  "t3_release");
        run(5, 0, 1, 0, 0, 1, 0, 0, S_WAKE,  "t3_wake2");
        run(1, 0, 1, 0, 0, 1, 1, 0, S_READY, "t3_ready2");

        // pd_req and activity together: pd_req wins
        run(1, 0, 1, 1, 1, 0, 0, 0, S_OFF,   "t5_pd_wins");
        run(2, 0, 1, 1, 1, 0, 0, 0, S_OFF,   "t5_pd_act_hold");
        run(1, 0, 1, 0, 0, 1, 0, 0, S_WAKE,  "t5_release");
        run(5, 0, 1, 0, 0, 1, 0, 0, S_WAKE,  "t5_wake");
        run(1, 0, 1, 0, 0, 1, 1, 0, S_READY, "t5_ready");

        // Reset mid-READY and mid-WAKE
        run(1, 0, 0, 0, 0, 0, 0, 0, S_OFF,   "t6_rst_ready");
        run(1, 0, 1, 0, 0, 0, 0, 0, S_OFF,   "t6_off");
        run(3, 0, 1, 0, 0, 1, 0, 0, S_WAKE,  "t6_wake_pre");
        run(1, 0, 0, 0, 0, 0, 0, 0, S_OFF,   "t6_rst_wake");
        run(1, 0, 1, 0, 0, 0, 0, 0, S_OFF,   "t6_off2");
        run(1, 0, 1, 0, 0, 1, 0, 0, S_WAKE,  "t6_pd_rise");
        run(5, 0, 1, 0, 0, 1, 0, 0, S_WAKE,  "t6_wake");
        run(1, 0, 1, 0, 0, 1, 1, 0, S_READY, "t6_ready");

        // Auto-sleep at the 10th idle READY edge, wake on activity
        run(2, 1, 0, 0, 0, 0, 0, 0, S_OFF,   "t4_reset");
        run(1, 1, 1, 0, 0, 0, 0, 0, S_OFF,   "t4_off_min");
        run(1, 1, 1, 0, 0, 1, 0, 0, S_WAKE,  "t4_pd_rise");
        run(5, 1, 1, 0, 0, 1, 0, 0, S_WAKE,  "t4_wake");
        run(1, 1, 1, 0, 0, 1, 1, 0, S_READY, "t4_ready");
        run(9, 1, 1, 0, 0, 1, 1, 0, S_READY, "t4_idle_count");
        run(1, 1, 1, 0, 0, 0, 0, 1, S_OFF,   "t4_sleep");
        run(2, 1, 1, 0, 0, 0, 0, 1, S_OFF,   "t4_asleep");
        run(2, 1, 1, 1, 1, 0, 0, 1, S_OFF,   "t4_pd_over_act");
        run(1, 1, 1, 0, 1, 1, 0, 0, S_WAKE,  "t4_wake_on_act");
        run(5, 1, 1, 0, 0, 1, 0, 0, S_WAKE,  "t4_wake");
        run(1, 1, 1, 0, 0, 1, 1, 0, S_READY, "t4_ready2");

        // Activity every 8th edge keeps the idle timer from expiring
        for (int i = 0; i < 200; i++)
            step(1, 1, 0, (i % 8 == 7), 1, 1, 0, S_READY, "t5_no_sleep");
        run(1, 1, 1, 1, 1, 0, 0, 0, S_OFF,   "t5_idle_pd_wins");
        run(1, 1, 1, 0, 0, 0, 0, 0, S_OFF,   "t5_idle_off");
        run(1, 1, 1, 0, 0, 1, 0, 0, S_WAKE,  "t5_idle_wake");

        // OFF_MIN=3, WAKE_CYCLES=1: PD at edge 4, ADC_ready at edge 5
        run(2, 2, 0, 0, 0, 0, 0, 0, S_OFF,   "t6b_reset");
        run(3, 2, 1, 0, 0, 0, 0, 0, S_OFF,   "t6b_off_min");
        run(1, 2, 1, 0, 0, 1, 0, 0, S_WAKE,  "t6b_pd_rise");
        run(1, 2, 1, 0, 0, 1, 1, 0, S_READY, "t6b_ready_rise");
        run(3, 2, 1, 0, 0, 1, 1, 0, S_READY, "t6b_ready_hold");

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
